adc_responder: RTL and testbench

Serial-side responder for the iceFUN ADC request protocol, running at 250 kbaud, 8N1.
- Receives a one-byte channel request: 0xA1..0xA4 selects channels 1..4.
- Answers with two bytes carrying a 10-bit sample: low byte first, then {6'b0, value[9:8]}.
- Used as the ADC-side endpoint: a bench model for the reader side, or a second FPGA serving samples to a host.
- Contains its own serial receiver and transmitter, so every register has a defined reset state.

---
 rtl/adc_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_adc_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// adc_responder: serial ADC endpoint. It takes a one-byte channel request (0xA1..0xA4) and
// answers with the 10-bit sample of that channel as two 8N1 bytes, low byte first.
module adc_responder #(
  parameter int unsigned TICKS_PER_BIT  = 48,
  parameter int unsigned RESPONSE_DELAY = 96,
  parameter int unsigned INTER_BYTE_GAP = 48
) (
  input  logic       clock12MHz,
  input  logic       reset,
  input  logic       serialIn,
  output logic       serialOut,
  input  logic [9:0] sample1,
  input  logic [9:0] sample2,
  input  logic [9:0] sample3,
  input  logic [9:0] sample4,
  output logic       busy,
  output logic [1:0] activeChannel,
  output logic       replyDone,
  output logic       cmdError
);

  localparam int unsigned TickW   = $clog2(TICKS_PER_BIT);
  localparam int unsigned MaxWait = (RESPONSE_DELAY > INTER_BYTE_GAP) ? RESPONSE_DELAY
                                                                      : INTER_BYTE_GAP;
  localparam int unsigned WaitW   = $clog2(MaxWait + 1);

  localparam logic [TickW-1:0] TickLast   = TickW'(TICKS_PER_BIT - 1);
  localparam logic [TickW-1:0] TickPenult = TickW'(TICKS_PER_BIT - 2);
  localparam logic [TickW-1:0] TickHalf   = TickW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [WaitW-1:0] DelayLast  = WaitW'(RESPONSE_DELAY - 1);
  localparam logic [WaitW-1:0] GapLast    = WaitW'(INTER_BYTE_GAP - 1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
  typedef enum logic [2:0] {StIdle, StDelay, StSendLo, StGap, StSendHi} tx_state_e;

  logic             sync1_q, sync2_q;
  rx_state_e        rx_state_q;
  logic [TickW-1:0] rx_tick_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q;  // high for one cycle when a well-framed byte is in rx_shift_q
  logic             rx_err_q;    // high for one cycle on a zero stop bit

  tx_state_e        tx_state_q;
  logic [TickW-1:0] tx_tick_q;
  logic [3:0]       tx_bit_q;
  logic [8:0]       tx_shift_q;  // remaining data bits followed by the stop bit
  logic [WaitW-1:0] wait_q;
  logic [9:0]       snapshot_q;
  logic             reject_q;

  logic             is_cmd;
  logic             accept;
  logic [1:0]       cmd_chan;
  logic [9:0]       sel_sample;

  // Two-flop synchronizer for the asynchronous request line
  always_ff @(posedge clock12MHz or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serialIn;
      sync2_q <= sync1_q;
    end
  end

  // Receiver: qualify start bit at half a bit, sample data and stop bits at mid-bit
  always_ff @(posedge clock12MHz or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (!sync2_q) begin
            rx_state_q <= RxStart;
            rx_tick_q  <= '0;
          end
        end
        RxStart: begin
          if (rx_tick_q == TickHalf) begin
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            // Line back high at mid start bit: a glitch, drop it silently
            rx_state_q <= sync2_q ? RxIdle : RxData;
          end else begin
            rx_tick_q <= rx_tick_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_tick_q == TickLast) begin
            rx_tick_q  <= '0;
            rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_tick_q <= rx_tick_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_tick_q == TickLast) begin
            rx_tick_q <= '0;
            if (sync2_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RxIdle;
            end else begin
              rx_err_q   <= 1'b1;
              rx_state_q <= RxWaitHigh;
            end
          end else begin
            rx_tick_q <= rx_tick_q + 1'b1;
          end
        end
        RxWaitHigh: begin
          if (sync2_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Command decode and channel select for the byte completed this cycle
  always_comb begin
    is_cmd   = (rx_shift_q >= 8'hA1) && (rx_shift_q <= 8'hA4);
    cmd_chan = 2'(rx_shift_q - 8'hA1);
    accept   = rx_valid_q && is_cmd && !busy;
    case (cmd_chan)
      2'd0:    sel_sample = sample1;
      2'd1:    sel_sample = sample2;
      2'd2:    sel_sample = sample3;
      default: sel_sample = sample4;
    endcase
  end

  // Reply FSM: delay, low byte, gap, high byte; all outputs registered
  always_ff @(posedge clock12MHz or posedge reset) begin
    if (reset) begin
      tx_state_q    <= StIdle;
      tx_tick_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '1;
      wait_q        <= '0;
      snapshot_q    <= '0;
      reject_q      <= 1'b0;
      serialOut     <= 1'b1;
      busy          <= 1'b0;
      activeChannel <= 2'd0;
      replyDone     <= 1'b0;
    end else begin
      replyDone <= 1'b0;
      reject_q  <= rx_valid_q && !accept;
      case (tx_state_q)
        StIdle: begin
          if (accept) begin
            tx_state_q    <= StDelay;
            wait_q        <= '0;
            busy          <= 1'b1;
            activeChannel <= cmd_chan;
            snapshot_q    <= sel_sample;
          end
        end
        StDelay: begin
          if (wait_q == DelayLast) begin
            tx_state_q <= StSendLo;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, snapshot_q[7:0]};
            serialOut  <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StSendLo, StSendHi: begin
          // Raise replyDone so it is visible during the final stop-bit cycle
          if (tx_state_q == StSendHi && tx_bit_q == 4'd9 && tx_tick_q == TickPenult) begin
            replyDone <= 1'b1;
          end
          if (tx_tick_q == TickLast) begin
            tx_tick_q <= '0;
            if (tx_bit_q == 4'd9) begin
              serialOut <= 1'b1;
              if (tx_state_q == StSendLo) begin
                tx_state_q <= StGap;
                wait_q     <= '0;
              end else begin
                tx_state_q <= StIdle;
                busy       <= 1'b0;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              serialOut  <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end
          end else begin
            tx_tick_q <= tx_tick_q + 1'b1;
          end
        end
        StGap: begin
          if (wait_q == GapLast) begin
            tx_state_q <= StSendHi;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, 6'b0, snapshot_q[9:8]};
            serialOut  <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // Framing errors flag at the stop sample, rejected bytes one cycle later
  assign cmdError = rx_err_q | reject_q;

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed bench for adc_responder. Drives request bytes, decodes the
// reply line with its own 8N1 receiver and checks bytes, timing and status pulses.
module tb_adc_responder;

  localparam int TPB         = 48;
  localparam int RD          = 96;
  localparam int GAP         = 48;
  localparam int ReplyCycles = RD + GAP + 20 * TPB;  // busy duration

  logic       clock12MHz = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       serialOut;
  logic [9:0] sample1, sample2, sample3, sample4;
  logic       busy;
  logic [1:0] activeChannel;
  logic       replyDone;
  logic       cmdError;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int err_cnt       = 0;
  int done_cnt      = 0;
  int done_cyc      = -1;
  int busy_rise_cnt = 0;
  int busy_rise_cyc = -1;
  int idle_bad      = 0;
  bit idle_watch    = 1'b0;

  logic [7:0] rx_bytes[$];
  int         start_cycs[$];

  adc_responder #(
    .TICKS_PER_BIT (TPB),
    .RESPONSE_DELAY(RD),
    .INTER_BYTE_GAP(GAP)
  ) dut (
    .clock12MHz   (clock12MHz),
    .reset        (reset),
    .serialIn     (serialIn),
    .serialOut    (serialOut),
    .sample1      (sample1),
    .sample2      (sample2),
    .sample3      (sample3),
    .sample4      (sample4),
    .busy         (busy),
    .activeChannel(activeChannel),
    .replyDone    (replyDone),
    .cmdError     (cmdError)
  );

  initial forever #5 clock12MHz = ~clock12MHz;

  initial forever begin
    @(posedge clock12MHz);
    cyc++;
  end

  // Status pulse and busy-edge recorder
  initial begin
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clock12MHz);
      if (cmdError === 1'b1) err_cnt++;
      if (replyDone === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy === 1'b1 && !busy_prev) begin
        busy_rise_cnt++;
        busy_rise_cyc = cyc;
      end
      busy_prev = (busy === 1'b1);
      if (idle_watch && (serialOut !== 1'b1 || busy !== 1'b0 || replyDone !== 1'b0 ||
                         cmdError !== 1'b0)) idle_bad++;
    end
  end

  // Reply-line decoder: mid-bit sampling, LSB first
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clock12MHz);
      if (serialOut === 1'b0 && reset === 1'b0) begin
        start_cycs.push_back(cyc);
        repeat (TPB / 2) @(negedge clock12MHz);
        for (int i = 0; i < 8; i++) begin
          repeat (TPB) @(negedge clock12MHz);
          b[i] = serialOut;
        end
        repeat (TPB) @(negedge clock12MHz);
        rx_bytes.push_back(b);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock12MHz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serialIn = 1'b0;
    repeat (TPB) @(negedge clock12MHz);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (TPB) @(negedge clock12MHz);
    end
    serialIn = stop;
    repeat (TPB) @(negedge clock12MHz);
    serialIn = 1'b1;
  endtask

  task automatic clear_mon();
    rx_bytes.delete();
    start_cycs.delete();
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int n    = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clock12MHz);
      n++;
    end
    check_eq({tag, " reply finished"}, 32'(done_cnt != base), 1);
    @(negedge clock12MHz);
    check_eq({tag, " busy low after reply"}, busy, 1'b0);
  endtask

  task automatic check_reply(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] g0, g1;
    g0 = 'x;
    g1 = 'x;
    if (rx_bytes.size() > 0) g0 = rx_bytes[0];
    if (rx_bytes.size() > 1) g1 = rx_bytes[1];
    check_eq({tag, " byte count"}, rx_bytes.size(), 2);
    check_eq({tag, " low byte"}, g0, lo);
    check_eq({tag, " high byte"}, g1, hi);
  endtask

  task automatic check_timing(input string tag);
    int s0, s1;
    s0 = (start_cycs.size() > 0) ? start_cycs[0] : -1;
    s1 = (start_cycs.size() > 1) ? start_cycs[1] : -1;
    // busy rises at T+1, first start bit at T+1+RD, replyDone on the last busy cycle
    check_eq({tag, " start-bit latency"}, s0 - busy_rise_cyc, RD);
    check_eq({tag, " byte spacing"}, s1 - s0, 10 * TPB + GAP);
    check_eq({tag, " replyDone latency"}, done_cyc - busy_rise_cyc, ReplyCycles - 1);
  endtask

  initial begin
    int e0, d0, b0, n;
    serialIn = 1'b1;
    sample1  = '0;
    sample2  = '0;
    sample3  = '0;
    sample4  = '0;
    reset    = 1'b1;
    idle(3);
    check_eq("reset serialOut", serialOut, 1'b1);
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset activeChannel", activeChannel, 2'd0);
    check_eq("reset replyDone", replyDone, 1'b0);
    check_eq("reset cmdError", cmdError, 1'b0);
    reset = 1'b0;

    idle_watch = 1'b1;
    idle(2000);
    idle_watch = 1'b0;
    check_eq("idle anomalies", idle_bad, 0);
    check_eq("idle no bytes", rx_bytes.size(), 0);

    // Channel 2 basic reply with latency checks
    sample2 = 10'h2B7;
    e0 = err_cnt;
    clear_mon();
    send_byte(8'hA2, 1'b1);
    wait_done("ch2");
    check_eq("ch2 activeChannel", activeChannel, 2'd1);
    check_reply("ch2", 8'hB7, 8'h02);
    check_timing("ch2");
    check_eq("ch2 no cmdError", err_cnt - e0, 0);

    // Snapshot holds while the live sample changes during the delay
    sample4 = 10'h3FF;
    clear_mon();
    send_byte(8'hA4, 1'b1);
    check_eq("ch4 busy in delay", busy, 1'b1);
    sample4 = 10'h000;
    wait_done("ch4");
    check_eq("ch4 activeChannel", activeChannel, 2'd3);
    check_reply("ch4", 8'hFF, 8'h03);

    sample1 = 10'h000;
    sample4 = 10'h155;
    clear_mon();
    send_byte(8'hA1, 1'b1);
    wait_done("ch1 zero");
    check_eq("ch1 zero activeChannel", activeChannel, 2'd0);
    check_reply("ch1 zero", 8'h00, 8'h00);

    // Bad value, framing error, glitch
    e0 = err_cnt;
    d0 = done_cnt;
    b0 = busy_rise_cnt;
    clear_mon();
    send_byte(8'h55, 1'b1);
    idle(100);
    check_eq("non-command cmdError", err_cnt - e0, 1);
    send_byte(8'hA1, 1'b0);
    idle(100);
    check_eq("framing cmdError", err_cnt - e0, 2);
    serialIn = 1'b0;
    idle(10);
    serialIn = 1'b1;
    idle(300);
    check_eq("glitch no cmdError", err_cnt - e0, 2);
    check_eq("bad bytes no replyDone", done_cnt - d0, 0);
    check_eq("bad bytes no busy", busy_rise_cnt - b0, 0);
    check_eq("bad bytes no reply", rx_bytes.size(), 0);

    // Command while busy is rejected; the running reply is unaffected
    sample3 = 10'h15A;
    sample1 = 10'h0C3;
    e0 = err_cnt;
    d0 = done_cnt;
    b0 = busy_rise_cnt;
    clear_mon();
    send_byte(8'hA3, 1'b1);
    idle(80);
    send_byte(8'hA1, 1'b1);
    wait_done("ch3 busy");
    check_eq("ch3 busy activeChannel", activeChannel, 2'd2);
    check_reply("ch3 busy", 8'h5A, 8'h01);
    check_eq("ch3 busy cmdError", err_cnt - e0, 1);
    idle(1500);
    check_eq("ch3 busy single reply", done_cnt - d0, 1);
    check_eq("ch3 busy single accept", busy_rise_cnt - b0, 1);
    clear_mon();
    send_byte(8'hA1, 1'b1);
    wait_done("ch1 after");
    check_eq("ch1 after activeChannel", activeChannel, 2'd0);
    check_reply("ch1 after", 8'hC3, 8'h00);

    // Reset in the 5th data bit of the low byte
    sample2 = 10'h2B7;
    clear_mon();
    send_byte(8'hA2, 1'b1);
    n = 0;
    while (serialOut !== 1'b0 && n < 300) begin
      @(negedge clock12MHz);
      n++;
    end
    check_eq("reply start seen", 32'(serialOut === 1'b0), 1);
    repeat (5 * TPB + TPB / 2 - 1) @(negedge clock12MHz);
    reset = 1'b1;
    #1;
    check_eq("mid-frame reset serialOut", serialOut, 1'b1);
    check_eq("mid-frame reset busy", busy, 1'b0);
    check_eq("mid-frame reset activeChannel", activeChannel, 2'd0);
    idle(3);
    reset = 1'b0;
    idle(600);
    clear_mon();
    sample2 = 10'h1A5;
    send_byte(8'hA2, 1'b1);
    wait_done("post-reset");
    check_eq("post-reset activeChannel", activeChannel, 2'd1);
    check_reply("post-reset", 8'hA5, 8'h01);
    check_timing("post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
